// File: rtl/desc_rr_scheduler_pkg.sv
// Shared descriptor definitions for the descriptor scheduling path.
// Provides the default descriptor slot count, the default outstanding
// limit and a constant-evaluable ceiling-log2 helper used to size indices
// and counters.
package desc_rr_scheduler_pkg;

   localparam int DESC_MAX_DEFAULT    = 16;
   localparam int OUTSTANDING_DEFAULT = 4;

   // Ceiling log2 for values >= 2. Used only for sizing parameters.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/desc_rr_scheduler_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin selector.
// Picks the lowest requesting index strictly above last_idx. If there is
// none, it wraps around and picks the lowest requesting index overall.
//   req      : request vector, one bit per descriptor slot
//   last_idx : index granted most recently
//   grant    : one-hot grant (all zero when no request)
//   idx      : binary index of the granted slot
//   any      : at least one request is present
module rr_arbiter
   import desc_rr_scheduler_pkg::*;
#(
   parameter  int N     = DESC_MAX_DEFAULT,
   localparam int IDX_W = clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_idx,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [N-1:0] mask;
   logic [N-1:0] pick;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      mask  = '0;
      grant = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i > int'(last_idx));
      end
      // Masked search first; fall back to the full vector to wrap past 0.
      pick = ((req & mask) != '0) ? (req & mask) : req;
      // Scanning downward means the last hit is the lowest set bit.
      for (int i = N - 1; i >= 0; i--) begin
         if (pick[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
         end
      end
      any = |req;
   end

endmodule

// File: rtl/desc_rr_scheduler.sv
// desc_rr_scheduler: collects descriptor requests into a pending bitmap
// and issues them one at a time, round-robin, through a valid/ready output
// register, limited by a count of issued-but-not-completed descriptors.
//   clk, rst_n   : clock, synchronous active-low reset
//   req_set      : one-cycle request pulses, one bit per descriptor
//   sched_valid  : sched_idx holds a scheduled descriptor
//   sched_idx    : scheduled descriptor index
//   sched_ready  : downstream accepts sched_idx
//   cmpl_vld     : one issued descriptor completed
//   pending_out  : registered pending bitmap
//   inflight_cnt : issued-not-completed count (held output included)
//   cmpl_err     : sticky, completion seen while nothing was in flight
module desc_rr_scheduler
   import desc_rr_scheduler_pkg::*;
#(
   parameter  int MAX_DESC        = DESC_MAX_DEFAULT,
   parameter  int MAX_OUTSTANDING = OUTSTANDING_DEFAULT,
   localparam int IDX_W           = clog2(MAX_DESC),
   localparam int CNT_W           = clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [MAX_DESC-1:0] req_set,
   output logic                sched_valid,
   output logic [IDX_W-1:0]    sched_idx,
   input  logic                sched_ready,
   input  logic                cmpl_vld,
   output logic [MAX_DESC-1:0] pending_out,
   output logic [CNT_W-1:0]    inflight_cnt,
   output logic                cmpl_err
);

   logic [MAX_DESC-1:0] pending;
   logic [IDX_W-1:0]    last_idx;
   logic [CNT_W-1:0]    inflight;

   logic [MAX_DESC-1:0] grant;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_any;

   logic has_credit;
   logic load;
   logic cmpl_take;

   rr_arbiter #(.N(MAX_DESC)) u_arb (
      .req      (pending),
      .last_idx (last_idx),
      .grant    (grant),
      .idx      (arb_idx),
      .any      (arb_any)
   );

   always_comb begin
      // A completion arriving this cycle frees its credit immediately.
      has_credit = (inflight < CNT_W'(MAX_OUTSTANDING)) || cmpl_vld;
      load       = (!sched_valid || sched_ready) && arb_any && has_credit;
      cmpl_take  = cmpl_vld && (inflight != '0);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending     <= '0;
         sched_valid <= 1'b0;
         sched_idx   <= '0;
         last_idx    <= IDX_W'(MAX_DESC - 1);
         inflight    <= '0;
         cmpl_err    <= 1'b0;
      end else begin
         // OR-ing req_set after the clear lets a fresh request win.
         pending <= (pending & ~(load ? grant : '0)) | req_set;

         if (load) begin
            sched_valid <= 1'b1;
            sched_idx   <= arb_idx;
            last_idx    <= arb_idx;
         end else if (sched_valid && sched_ready) begin
            sched_valid <= 1'b0;
         end

         case ({load, cmpl_take})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase

         if (cmpl_vld && (inflight == '0)) begin
            cmpl_err <= 1'b1;
         end
      end
   end

   assign pending_out  = pending;
   assign inflight_cnt = inflight;

endmodule
